cpu_control_unit: RTL and testbench



---
 rtl/cpu_control_unit.sv | 155 +++++++++++++++
 tb/tb_cpu_control_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cpu_control_unit                                             |
// | Description : Multi-cycle fetch/decode/execute/writeback sequencer + ALU   |
// |               driving a 4x4-bit register file. Optional macro FLAGS_EN     |
// |               enables registered zero/carry flags.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cpu_control_unit #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [7:0]      imem_data,
  output logic [1:0]      rf_rs1,
  output logic [1:0]      rf_rs2,
  input  logic [3:0]      rf_rd1,
  input  logic [3:0]      rf_rd2,
  output logic            rf_we,
  output logic [1:0]      rf_rd,
  output logic [3:0]      rf_wdata,
  output logic            busy,
  output logic            flag_z,
  output logic            flag_c
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_AND = 2'b10;
  localparam logic [1:0] c_OP_LDI = 2'b11;

  state_t            r_state;
  state_t            w_next_state;
  logic [PC_W-1:0]   r_pc;
  logic [7:0]        r_ir;
  logic [3:0]        r_result;
  logic [3:0]        w_alu_result;
  logic              w_alu_carry;
  logic [4:0]        w_sum;
  logic [4:0]        w_diff;
  logic [1:0]        w_op;

  assign w_op = r_ir[7:6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_FETCH && imem_valid) begin
        r_ir <= imem_data;
        r_pc <= r_pc + 1'b1;
      end
      if (r_state == S_EXECUTE) begin
        r_result <= w_alu_result;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (run) w_next_state = S_FETCH;
      S_FETCH:     if (imem_valid) w_next_state = S_DECODE;
      S_DECODE:    w_next_state = S_EXECUTE;
      S_EXECUTE:   w_next_state = S_WRITEBACK;
      S_WRITEBACK: w_next_state = run ? S_FETCH : S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Bit 4 of the 5-bit difference is the unsigned borrow (rs1 < rs2).
  assign w_sum  = {1'b0, rf_rd1} + {1'b0, rf_rd2};
  assign w_diff = {1'b0, rf_rd1} - {1'b0, rf_rd2};

  always_comb begin
    w_alu_result = '0;
    w_alu_carry  = 1'b0;
    case (w_op)
      c_OP_ADD: begin
        w_alu_result = w_sum[3:0];
        w_alu_carry  = w_sum[4];
      end
      c_OP_SUB: begin
        w_alu_result = w_diff[3:0];
        w_alu_carry  = w_diff[4];
      end
      c_OP_AND: w_alu_result = rf_rd1 & rf_rd2;
      c_OP_LDI: w_alu_result = r_ir[3:0];
      default:  w_alu_result = '0;
    endcase
  end

`ifdef FLAGS_EN
  logic r_z_next;
  logic r_c_next;
  logic r_flag_z;
  logic r_flag_c;

  // Next-flag values are captured with the result; the visible flags commit
  // together with the register write so LDI can leave them untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_z_next <= 1'b0;
      r_c_next <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
    end else begin
      if (r_state == S_EXECUTE) begin
        r_z_next <= (w_alu_result == 4'd0);
        r_c_next <= w_alu_carry;
      end
      if (r_state == S_WRITEBACK && w_op != c_OP_LDI) begin
        r_flag_z <= r_z_next;
        r_flag_c <= r_c_next;
      end
    end
  end

  assign flag_z = r_flag_z;
  assign flag_c = r_flag_c;
`else
  logic w_unused_carry;
  assign w_unused_carry = w_alu_carry;
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif

  // Write strobe is decoded from state so an async reset removes it at once.
  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign rf_rs1    = r_ir[3:2];
  assign rf_rs2    = r_ir[1:0];
  assign rf_we     = (r_state == S_WRITEBACK);
  assign rf_rd     = r_ir[5:4];
  assign rf_wdata  = r_result;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cpu_control_unit                                          |
// | Description : Randomized self-checking bench for cpu_control_unit with a   |
// |               register-file environment and an instruction-level model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cpu_control_unit;
  localparam int PC_W = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            run;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [7:0]      imem_data;
  logic [1:0]      rf_rs1, rf_rs2, rf_rd;
  logic [3:0]      rf_rd1, rf_rd2, rf_wdata;
  logic            rf_we, busy, flag_z, flag_c;

  int checks = 0;
  int failures = 0;

  // Reference model state: architectural registers, pc and flags.
  int m_rf [4];
  int m_pc;
  int m_z, m_c;

  logic [3:0] env_rf [4];

  cpu_control_unit #(.PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .busy(busy), .flag_z(flag_z), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  // Register file environment (what the DUT actually reads and writes).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) env_rf[i] <= 4'd0;
    end else if (rf_we) begin
      env_rf[rf_rd] <= rf_wdata;
    end
  end
  assign rf_rd1 = env_rf[rf_rs1];
  assign rf_rd2 = env_rf[rf_rs2];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 0;
    m_pc = 0;
    m_z  = 0;
    m_c  = 0;
  endtask

  // Runs one instruction starting at a negedge where the DUT is in FETCH.
  task automatic exec_one(input logic [7:0] instr, input int waits, input logic run_after,
                          input logic rst_in_wb, output int faddr, output int wrd, output int wval);
    int a, b, val, cy, op, rd;
    op = int'(instr[7:6]);
    rd = int'(instr[5:4]);
    faddr = int'(imem_addr);
    for (int w = 0; w < waits; w++) begin
      checks++;
      if (imem_req !== 1'b1 || int'(imem_addr) !== m_pc || rf_we !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL fetch_stall req=%b addr=%0d we=%b busy=%b, expected req=1 addr=%0d we=0 busy=1",
                 imem_req, imem_addr, rf_we, busy, m_pc);
      end
      imem_valid = 1'b0;
      imem_data  = 8'($urandom);
      @(negedge clk);
    end
    checks++;
    if (imem_req !== 1'b1 || int'(imem_addr) !== m_pc) begin
      failures++;
      $display("FAIL fetch req=%b addr=%0d, expected req=1 addr=%0d", imem_req, imem_addr, m_pc);
    end
    imem_valid = 1'b1;
    imem_data  = instr;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || rf_we !== 1'b0 || busy !== 1'b1 ||
        rf_rs1 !== instr[3:2] || rf_rs2 !== instr[1:0]) begin
      failures++;
      $display("FAIL decode req=%b we=%b busy=%b rs1=%0d rs2=%0d, expected req=0 we=0 busy=1 rs1=%0d rs2=%0d",
               imem_req, rf_we, busy, rf_rs1, rf_rs2, instr[3:2], instr[1:0]);
    end
    imem_valid = 1'($urandom);
    imem_data  = 8'($urandom);
    run        = rst_in_wb ? 1'b0 : run_after;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || busy !== 1'b1 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL execute we=%b busy=%b req=%b, expected we=0 busy=1 req=0", rf_we, busy, imem_req);
    end
    @(negedge clk);
    a = m_rf[instr[3:2]];
    b = m_rf[instr[1:0]];
    cy = 0;
    case (op)
      0: begin val = (a + b) % 16; cy = (a + b > 15) ? 1 : 0; end
      1: begin val = (a - b + 16) % 16; cy = (a < b) ? 1 : 0; end
      2: val = a & b;
      default: val = int'(instr[3:0]);
    endcase
    wrd  = int'(rf_rd);
    wval = int'(rf_wdata);
    checks++;
    if (rf_we !== 1'b1 || wrd !== rd || wval !== val) begin
      failures++;
      $display("FAIL writeback we=%b rd=%0d wdata=%0d, expected we=1 rd=%0d wdata=%0d",
               rf_we, rf_rd, rf_wdata, rd, val);
    end
    if (rst_in_wb) begin
      reset = 1'b1;
      #1;
      checks++;
      if (rf_we !== 1'b0 || busy !== 1'b0 || imem_req !== 1'b0 || imem_addr !== '0 ||
          rf_rs1 !== 2'd0 || rf_rs2 !== 2'd0 || rf_rd !== 2'd0 || rf_wdata !== 4'd0 ||
          flag_z !== 1'b0 || flag_c !== 1'b0) begin
        failures++;
        $display("FAIL reset_in_wb we=%b busy=%b req=%b addr=%0d rs1=%0d rs2=%0d rd=%0d wdata=%0d z=%b c=%b, expected all 0",
                 rf_we, busy, imem_req, imem_addr, rf_rs1, rf_rs2, rf_rd, rf_wdata, flag_z, flag_c);
      end
      model_reset();
      imem_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    m_rf[rd] = val;
    m_pc = (m_pc + 1) % (1 << PC_W);
`ifdef FLAGS_EN
    if (op != 3) begin
      m_z = (val == 0) ? 1 : 0;
      m_c = cy;
    end
`endif
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || busy !== run_after || imem_req !== run_after ||
        int'(flag_z) !== m_z || int'(flag_c) !== m_c) begin
      failures++;
      $display("FAIL after_wb we=%b busy=%b req=%b z=%b c=%b, expected we=0 busy=%b req=%b z=%0d c=%0d",
               rf_we, busy, imem_req, flag_z, flag_c, run_after, run_after, m_z, m_c);
    end
  endtask

  // From IDLE at a negedge: raise run and advance into FETCH.
  task automatic start_run();
    checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL idle busy=%b req=%b, expected busy=0 req=0", busy, imem_req);
    end
    run = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    run = 1'b0; imem_valid = 1'b0; imem_data = 8'h00; reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== '0 || rf_rs1 !== 2'd0 || rf_rs2 !== 2'd0 ||
        rf_we !== 1'b0 || rf_rd !== 2'd0 || rf_wdata !== 4'd0 || busy !== 1'b0 ||
        flag_z !== 1'b0 || flag_c !== 1'b0) begin
      failures++;
      $display("FAIL reset_values req=%b addr=%0d rs1=%0d rs2=%0d we=%b rd=%0d wdata=%0d busy=%b z=%b c=%b, expected all 0",
               imem_req, imem_addr, rf_rs1, rf_rs2, rf_we, rf_rd, rf_wdata, busy, flag_z, flag_c);
    end
    reset = 1'b0;
    imem_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0 || imem_addr !== '0) begin
      failures++;
      $display("FAIL idle_hold busy=%b req=%b addr=%0d, expected 0 0 0", busy, imem_req, imem_addr);
    end
    imem_valid = 1'b0;
  endtask

  task automatic test_program();
    int fa, rd, val, ez, ec;
    start_run();
    exec_one(8'hD5, 0, 1'b1, 1'b0, fa, rd, val);
    exec_one(8'hE3, 0, 1'b1, 1'b0, fa, rd, val);
    exec_one(8'h36, 0, 1'b1, 1'b0, fa, rd, val);
    checks++;
    if (rd !== 3 || val !== 8 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
      failures++;
      $display("FAIL add_plan rd=%0d wdata=%0d z=%b c=%b, expected rd=3 wdata=8 z=0 c=0", rd, val, flag_z, flag_c);
    end
    exec_one(8'hD3, 0, 1'b1, 1'b0, fa, rd, val);
    exec_one(8'hE5, 0, 1'b1, 1'b0, fa, rd, val);
    exec_one(8'h46, 0, 1'b1, 1'b0, fa, rd, val);
`ifdef FLAGS_EN
    ec = 1;
`else
    ec = 0;
`endif
    checks++;
    if (rd !== 0 || val !== 14 || int'(flag_c) !== ec) begin
      failures++;
      $display("FAIL sub_borrow rd=%0d wdata=%0d c=%b, expected rd=0 wdata=14 c=%0d", rd, val, flag_c, ec);
    end
    exec_one(8'hDA, 0, 1'b1, 1'b0, fa, rd, val);
    exec_one(8'hE5, 0, 1'b1, 1'b0, fa, rd, val);
    exec_one(8'hB6, 0, 1'b1, 1'b0, fa, rd, val);
    ez = ec;
    checks++;
    if (rd !== 3 || val !== 0 || int'(flag_z) !== ez || flag_c !== 1'b0) begin
      failures++;
      $display("FAIL and_zero rd=%0d wdata=%0d z=%b c=%b, expected rd=3 wdata=0 z=%0d c=0", rd, val, flag_z, flag_c, ez);
    end
  endtask

  task automatic test_fetch_stall();
    int fa, rd, val;
    exec_one(8'hC9, 3, 1'b1, 1'b0, fa, rd, val);
    checks++;
    if (rd !== 0 || val !== 9) begin
      failures++;
      $display("FAIL stall_result rd=%0d wdata=%0d, expected rd=0 wdata=9", rd, val);
    end
  endtask

  task automatic test_run_drop();
    int fa, rd, val, pc_before;
    pc_before = m_pc;
    exec_one(8'hF7, 1, 1'b0, 1'b0, fa, rd, val);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0 || int'(imem_addr) !== (pc_before + 1) % (1 << PC_W)) begin
      failures++;
      $display("FAIL run_drop busy=%b req=%b addr=%0d, expected busy=0 req=0 addr=%0d",
               busy, imem_req, imem_addr, (pc_before + 1) % (1 << PC_W));
    end
    start_run();
    exec_one(8'h1B, 0, 1'b1, 1'b0, fa, rd, val);
    checks++;
    if (fa !== (pc_before + 1) % (1 << PC_W)) begin
      failures++;
      $display("FAIL resume_pc addr=%0d, expected %0d", fa, (pc_before + 1) % (1 << PC_W));
    end
  endtask

  task automatic test_random();
    int fa, rd, val;
    logic ra;
    for (int n = 0; n < 60; n++) begin
      ra = ($urandom_range(0, 4) != 0);
      exec_one(8'($urandom), int'($urandom_range(0, 3)), ra, 1'b0, fa, rd, val);
      if (!ra) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        start_run();
      end
    end
  endtask

  task automatic test_reset_in_wb();
    int fa, rd, val;
    exec_one(8'h7F, 0, 1'b1, 1'b1, fa, rd, val);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || imem_addr !== '0 || env_rf[0] !== 4'd0 || env_rf[3] !== 4'd0) begin
      failures++;
      $display("FAIL post_reset busy=%b addr=%0d r0=%0d r3=%0d, expected 0 0 0 0", busy, imem_addr, env_rf[0], env_rf[3]);
    end
  endtask

  task automatic test_pc_wrap();
    int fa, rd, val;
    start_run();
    for (int i = 0; i < 17; i++) begin
      exec_one({2'b11, 2'(i), 4'(i)}, 0, 1'b1, 1'b0, fa, rd, val);
      checks++;
      if (fa !== i % 16) begin
        failures++;
        $display("FAIL pc_wrap step=%0d addr=%0d, expected %0d", i, fa, i % 16);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_program();
    test_fetch_stall();
    test_run_drop();
    test_random();
    test_reset_in_wb();
    test_pc_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
